// File: rtl/io_station_pkg.sv
// io_station_pkg: shared definitions for the queued IO station.
//   IO_OP_OMWRITE / IO_OP_TMREAD : operation codes carried on iOpCode
//   io_state_e                   : execution FSM states
package io_station_pkg;

  localparam logic [1:0] IO_OP_OMWRITE = 2'b00;
  localparam logic [1:0] IO_OP_TMREAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OMWRITE,
    ST_TMREQ,
    ST_COMMIT
  } io_state_e;

endpackage

// File: rtl/io_op_fifo.sv
// io_op_fifo: DEPTH x WIDTH synchronous FIFO holding queued IO operations.
//   clk, rst        : clock, asynchronous active-high reset (empties the queue)
//   push, push_data : write an entry (ignored when full)
//   pop, pop_data   : remove the head entry (ignored when empty); pop_data
//                     always shows the current head
//   count, full, empty : occupancy status
module io_op_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_station_queued.sv
// io_station_queued: queues IO operations and executes them in order.
//   Clock, Reset            : clock, asynchronous active-high reset
//   iOpValid/oOpReady       : operation push handshake (opcode, src0, src1, dst)
//   oOMEMWrite*             : one LANES word per cycle for OMWRITE
//   oTMEMReadAddress/oTMEMDataRequest, iTMEMReadData/iTMEMDataAvailable :
//                             TMEM read handshake with timeout
//   oCommit*/iCommitGranted : TMREAD result return handshake
//   oBusy                   : executing or queue non-empty
//   oTimeout                : one-cycle pulse after a TMEM read timed out
module io_station_queued
  import io_station_pkg::*;
#(
  parameter int unsigned LANES        = 3,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DST_W        = 7,
  parameter int unsigned TMEM_TIMEOUT = 255
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    iOpValid,
  output logic                    oOpReady,
  input  logic [1:0]              iOpCode,
  input  logic [LANES*WORD_W-1:0] iOpSrc0,
  input  logic [LANES*WORD_W-1:0] iOpSrc1,
  input  logic [DST_W-1:0]        iOpDst,
  output logic [WORD_W-1:0]       oOMEMWriteAddress,
  output logic [WORD_W-1:0]       oOMEMWriteData,
  output logic                    oOMEMWriteEnable,
  output logic [LANES*WORD_W-1:0] oTMEMReadAddress,
  output logic                    oTMEMDataRequest,
  input  logic [LANES*WORD_W-1:0] iTMEMReadData,
  input  logic                    iTMEMDataAvailable,
  output logic                    oCommitRequest,
  output logic [DST_W-1:0]        oCommitDestination,
  output logic [LANES*WORD_W-1:0] oCommitResult,
  input  logic                    iCommitGranted,
  output logic                    oBusy,
  output logic                    oTimeout
);

  localparam int unsigned ROW_W   = LANES * WORD_W;
  localparam int unsigned ENTRY_W = 2 + 2 * ROW_W + DST_W;
  localparam int unsigned LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WAIT_W  = $clog2(TMEM_TIMEOUT + 1);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;

  logic [1:0]         head_op;
  logic [ROW_W-1:0]   head_src0, head_src1;
  logic [DST_W-1:0]   head_dst;

  io_state_e          state_q, state_d;
  logic [ROW_W-1:0]   src0_q, src0_d, src1_q, src1_d, result_q, result_d;
  logic [DST_W-1:0]   dst_q, dst_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               op_done;

  assign fifo_wdata = {iOpCode, iOpSrc0, iOpSrc1, iOpDst};
  assign fifo_push  = iOpValid && !fifo_full;
  assign oOpReady   = !fifo_full;

  assign head_op   = fifo_rdata[ENTRY_W-1 -: 2];
  assign head_src0 = fifo_rdata[DST_W+ROW_W +: ROW_W];
  assign head_src1 = fifo_rdata[DST_W +: ROW_W];
  assign head_dst  = fifo_rdata[DST_W-1:0];

  io_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // op_done marks the edge where the current op retires; the next queued op
  // is popped on that same edge so consecutive ops run without a bubble.
  always_comb begin
    state_d   = state_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    dst_d     = dst_q;
    lane_d    = lane_q;
    wait_d    = wait_q;
    result_d  = result_q;
    timeout_d = 1'b0;
    op_done   = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: op_done = 1'b1;
      ST_OMWRITE: begin
        if (lane_q == LANE_W'(LANES - 1)) op_done = 1'b1;
        else                              lane_d  = lane_q + 1'b1;
      end
      ST_TMREQ: begin
        // Data on the timeout edge takes priority over the timeout.
        if (iTMEMDataAvailable) begin
          result_d = iTMEMReadData;
          state_d  = ST_COMMIT;
        end else if (wait_q == WAIT_W'(TMEM_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          op_done   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_COMMIT: if (iCommitGranted) op_done = 1'b1;
      default:   state_d = ST_IDLE;
    endcase

    if (op_done) begin
      state_d = ST_IDLE;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        case (head_op)
          IO_OP_OMWRITE, IO_OP_TMREAD: begin
            state_d = (head_op == IO_OP_OMWRITE) ? ST_OMWRITE : ST_TMREQ;
            src0_d  = head_src0;
            src1_d  = head_src1;
            dst_d   = head_dst;
            lane_d  = '0;
            wait_d  = '0;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      src0_q    <= '0;
      src1_q    <= '0;
      dst_q     <= '0;
      lane_q    <= '0;
      wait_q    <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      dst_q     <= dst_d;
      lane_q    <= lane_d;
      wait_q    <= wait_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
    end
  end

  assign oOMEMWriteEnable   = (state_q == ST_OMWRITE);
  assign oOMEMWriteAddress  = oOMEMWriteEnable ? src1_q[lane_q*WORD_W +: WORD_W] : '0;
  assign oOMEMWriteData     = oOMEMWriteEnable ? src0_q[lane_q*WORD_W +: WORD_W] : '0;
  assign oTMEMDataRequest   = (state_q == ST_TMREQ);
  assign oTMEMReadAddress   = oTMEMDataRequest ? src0_q : '0;
  assign oCommitRequest     = (state_q == ST_COMMIT);
  assign oCommitDestination = dst_q;
  assign oCommitResult      = result_q;
  assign oBusy              = (state_q != ST_IDLE) || (fifo_count != '0);
  assign oTimeout           = timeout_q;

endmodule
